// File: rtl/agu_pipelined_if.sv
// Handshake and operand bus between operand fetch, the pipelined AGU, and the memory/execute stage.
interface agu_pipelined_if #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned NUM_SLOTS      = 3,
  parameter int unsigned SIDEBAND_WIDTH = 128
) ();
  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_SLOTS-1:0]            mem_en_in;
  logic [NUM_SLOTS-1:0]            index_en_in;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] base_in;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] index_in;
  logic [NUM_SLOTS*2-1:0]          scale_in;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] disp_in;
  logic [SIDEBAND_WIDTH-1:0]       sideband_in;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_SLOTS*ADDR_WIDTH-1:0] addr_out;
  logic [NUM_SLOTS-1:0]            mem_en_out;
  logic [SIDEBAND_WIDTH-1:0]       sideband_out;
  logic [1:0]                      inflight_out;
  logic                            fault_out;

  modport master (
    output flush, in_valid, mem_en_in, index_en_in, base_in, index_in, scale_in, disp_in,
           sideband_in, out_ready,
    input  in_ready, out_valid, addr_out, mem_en_out, sideband_out, inflight_out, fault_out
  );

  modport slave (
    input  flush, in_valid, mem_en_in, index_en_in, base_in, index_in, scale_in, disp_in,
           sideband_in, out_ready,
    output in_ready, out_valid, addr_out, mem_en_out, sideband_out, inflight_out, fault_out
  );
endinterface

// File: rtl/agu_pipelined.sv
// Two-stage pipelined AGU: per slot addr = base + (index << scale) + disp, valid/ready with flush.
// Optional 48-bit canonical-address check is enabled by defining AGU_CANONICAL_CHECK_EN.
module agu_pipelined #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned NUM_SLOTS      = 3,
  parameter int unsigned SIDEBAND_WIDTH = 128
) (
  input logic              clk,
  input logic              reset,
  agu_pipelined_if.slave   bus
);
  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned NS = NUM_SLOTS;
  localparam int unsigned SW = SIDEBAND_WIDTH;
  localparam int unsigned VW = NS * AW;

  logic          s1_valid_q, s1_valid_d;
  logic          s2_valid_q, s2_valid_d;
  logic [VW-1:0] s1_bd_q, s1_bd_d;
  logic [VW-1:0] s1_ix_q, s1_ix_d;
  logic [NS-1:0] s1_mem_en_q, s1_mem_en_d;
  logic [SW-1:0] s1_sb_q, s1_sb_d;
  logic [VW-1:0] s2_addr_q, s2_addr_d;
  logic [NS-1:0] s2_mem_en_q, s2_mem_en_d;
  logic [SW-1:0] s2_sb_q, s2_sb_d;
  logic [1:0]    inflight_q, inflight_d;

  logic          s2_adv_c, s1_adv_c, in_ready_c, accept_c, emit_c;
  logic [VW-1:0] sum_c;

  // Handshake: S2 drains first, S1 follows; flush blocks acceptance outright.
  always_comb begin
    s2_adv_c   = !s2_valid_q || bus.out_ready;
    s1_adv_c   = s1_valid_q && s2_adv_c;
    in_ready_c = !bus.flush && (!s1_valid_q || s1_adv_c);
    accept_c   = bus.in_valid && in_ready_c;
    emit_c     = s2_valid_q && bus.out_ready;
  end

  // S1: split the address into base+disp and the scaled index term.
  always_comb begin
    s1_bd_d     = s1_bd_q;
    s1_ix_d     = s1_ix_q;
    s1_mem_en_d = s1_mem_en_q;
    s1_sb_d     = s1_sb_q;
    if (accept_c) begin
      s1_mem_en_d = bus.mem_en_in;
      s1_sb_d     = bus.sideband_in;
      for (int unsigned i = 0; i < NS; i++) begin
        s1_bd_d[i*AW +: AW] = bus.base_in[i*AW +: AW] + bus.disp_in[i*AW +: AW];
        s1_ix_d[i*AW +: AW] = bus.index_en_in[i]
                            ? (bus.index_in[i*AW +: AW] << bus.scale_in[2*i +: 2])
                            : '0;
      end
    end
  end

  // S2: final modulo add; non-memory slots read as zero.
  always_comb begin
    for (int unsigned i = 0; i < NS; i++) begin
      sum_c[i*AW +: AW] = s1_mem_en_q[i] ? (s1_bd_q[i*AW +: AW] + s1_ix_q[i*AW +: AW]) : '0;
    end
    s2_addr_d   = s2_addr_q;
    s2_mem_en_d = s2_mem_en_q;
    s2_sb_d     = s2_sb_q;
    if (s1_adv_c) begin
      s2_addr_d   = sum_c;
      s2_mem_en_d = s1_mem_en_q;
      s2_sb_d     = s1_sb_q;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    inflight_d = inflight_q + 2'(accept_c) - 2'(emit_c);
    if (accept_c) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv_c) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv_c) begin
      s2_valid_d = 1'b1;
    end else if (emit_c) begin
      s2_valid_d = 1'b0;
    end
    if (bus.flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      inflight_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_bd_q     <= '0;
      s1_ix_q     <= '0;
      s1_mem_en_q <= '0;
      s1_sb_q     <= '0;
      s2_addr_q   <= '0;
      s2_mem_en_q <= '0;
      s2_sb_q     <= '0;
      inflight_q  <= 2'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_bd_q     <= s1_bd_d;
      s1_ix_q     <= s1_ix_d;
      s1_mem_en_q <= s1_mem_en_d;
      s1_sb_q     <= s1_sb_d;
      s2_addr_q   <= s2_addr_d;
      s2_mem_en_q <= s2_mem_en_d;
      s2_sb_q     <= s2_sb_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef AGU_CANONICAL_CHECK_EN
  logic s2_fault_q, s2_fault_d;

  // Flag any enabled slot whose bits [AW-1:47] are not a uniform sign extension.
  always_comb begin
    s2_fault_d = s2_fault_q;
    if (s1_adv_c) begin
      s2_fault_d = 1'b0;
      for (int unsigned i = 0; i < NS; i++) begin
        if (s1_mem_en_q[i] && (|sum_c[i*AW+47 +: AW-47]) && !(&sum_c[i*AW+47 +: AW-47])) begin
          s2_fault_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_fault_q <= 1'b0;
    end else begin
      s2_fault_q <= s2_fault_d;
    end
  end

  assign bus.fault_out = s2_fault_q;
`else
  assign bus.fault_out = 1'b0;
`endif

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = s2_valid_q;
  assign bus.addr_out     = s2_addr_q;
  assign bus.mem_en_out   = s2_mem_en_q;
  assign bus.sideband_out = s2_sb_q;
  assign bus.inflight_out = inflight_q;
endmodule

// File: tb/tb_agu_pipelined.sv
// Scoreboard bench for agu_pipelined: directed ops push expected results, a negedge monitor pops them.
module tb_agu_pipelined;
  localparam int unsigned AW = 64;
  localparam int unsigned NS = 3;
  localparam int unsigned SW = 128;
  localparam int unsigned VW = NS * AW;
`ifdef AGU_CANONICAL_CHECK_EN
  localparam logic CANON = 1'b1;
`else
  localparam logic CANON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  agu_pipelined_if #(.ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SIDEBAND_WIDTH(SW)) bus ();

  agu_pipelined #(.ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SIDEBAND_WIDTH(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [VW-1:0] addr;
    logic [NS-1:0] mem_en;
    logic [SW-1:0] sb;
    logic          fault;
  } exp_t;

  typedef struct {
    logic [VW-1:0]   base;
    logic [VW-1:0]   index;
    logic [VW-1:0]   disp;
    logic [2*NS-1:0] scale;
    logic [NS-1:0]   mem_en;
    logic [NS-1:0]   index_en;
    logic [SW-1:0]   sb;
    exp_t            ex;
  } op_t;

  exp_t expq[$];
  exp_t cur_exp;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  op_t  op_a, op_b, op_w, op_g, op_k1, op_k2;
  op_t  op_c[4];
  op_t  op_d[5];
  op_t  op_f[3];
  op_t  op_h[2];
  int   b2b_inf[4]   = '{0, 1, 2, 2};
  int   stall_rdy[5] = '{1, 1, 0, 0, 0};
  int   stall_inf[5] = '{0, 1, 2, 2, 2};
  int   nxt;
  logic [VW-1:0] held_addr;
  logic [SW-1:0] held_sb;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Slot-0-only op; slots 1 and 2 are not memory accesses.
  function automatic op_t op1(input logic [63:0] b, input logic [63:0] ix, input logic [1:0] s,
                              input logic [63:0] d, input logic ie, input logic [SW-1:0] sb,
                              input logic [63:0] ea, input logic ef);
    op_t o;
    o.base      = {128'h0, b};
    o.index     = {128'h0, ix};
    o.disp      = {128'h0, d};
    o.scale     = {4'h0, s};
    o.mem_en    = 3'b001;
    o.index_en  = {2'b00, ie};
    o.sb        = sb;
    o.ex.addr   = {128'h0, ea};
    o.ex.mem_en = 3'b001;
    o.ex.sb     = sb;
    o.ex.fault  = ef;
    return o;
  endfunction

  task automatic drive(input op_t o);
    bus.base_in     = o.base;
    bus.index_in    = o.index;
    bus.disp_in     = o.disp;
    bus.scale_in    = o.scale;
    bus.mem_en_in   = o.mem_en;
    bus.index_en_in = o.index_en;
    bus.sideband_in = o.sb;
    bus.in_valid    = 1'b1;
    cur_exp         = o.ex;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc();
  endtask

  // Hold the op on the bus until the handshake completes, bounded.
  task automatic send(input op_t o);
    bit done = 1'b0;
    drive(o);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      done = bus.in_ready;
      cyc();
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready low for 20 cycles want acceptance");
    end
    idle();
  endtask

  // Monitor pops on every output transfer; stimulus pushes on every input transfer.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got addr %h want no output", bus.addr_out);
      end else begin
        mon_e = expq.pop_front();
        chk("out_addr", 256'(bus.addr_out), 256'(mon_e.addr));
        chk("out_mem_en", 256'(bus.mem_en_out), 256'(mon_e.mem_en));
        chk("out_sideband", 256'(bus.sideband_out), 256'(mon_e.sb));
        chk("out_fault", 256'(bus.fault_out), 256'(mon_e.fault));
      end
    end
    if (!reset && !bus.flush && bus.in_valid && bus.in_ready) begin
      expq.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.base_in     = '0;
    bus.index_in    = '0;
    bus.disp_in     = '0;
    bus.scale_in    = '0;
    bus.mem_en_in   = '0;
    bus.index_en_in = '0;
    bus.sideband_in = '0;
    cur_exp         = '{default: '0};

    // 0x1000 + (0x10<<3) - 8 = 0x1078; disabled slots carry junk that must read as zero.
    op_a = op1(64'h1000, 64'h10, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 128'hA, 64'h1078, 1'b0);
    op_a.base = {64'h7777, 64'h0000_8000_0000_0000, 64'h1000};
    op_a.disp = {64'h0, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8};
    // All slots: 0x2000+3+0x10, 0x100 (index disabled), (4<<2)+4.
    op_b.base        = {64'h0, 64'h100, 64'h2000};
    op_b.index       = {64'h4, 64'h7, 64'h3};
    op_b.disp        = {64'h4, 64'h0, 64'h10};
    op_b.scale       = {2'd2, 2'd1, 2'd0};
    op_b.mem_en      = 3'b111;
    op_b.index_en    = 3'b101;
    op_b.sb          = 128'hB;
    op_b.ex.addr     = {64'h14, 64'h100, 64'h2013};
    op_b.ex.mem_en   = 3'b111;
    op_b.ex.sb       = 128'hB;
    op_b.ex.fault    = 1'b0;
    op_c[0] = op1(64'h100, 64'h1, 2'd1, 64'h0, 1'b1, 128'hC1, 64'h102, 1'b0);
    op_c[1] = op1(64'h200, 64'h2, 2'd1, 64'h0, 1'b1, 128'hC2, 64'h204, 1'b0);
    op_c[2] = op1(64'h300, 64'h3, 2'd1, 64'h0, 1'b1, 128'hC3, 64'h306, 1'b0);
    op_c[3] = op1(64'h400, 64'h4, 2'd1, 64'h0, 1'b1, 128'hC4, 64'h408, 1'b0);
    op_d[0] = op1(64'h4000, 64'h0, 2'd2, 64'h8, 1'b1, 128'hD0, 64'h4008, 1'b0);
    op_d[1] = op1(64'h4010, 64'h1, 2'd2, 64'h8, 1'b1, 128'hD1, 64'h401C, 1'b0);
    op_d[2] = op1(64'h4020, 64'h2, 2'd2, 64'h8, 1'b1, 128'hD2, 64'h4030, 1'b0);
    op_d[3] = op1(64'h4030, 64'h3, 2'd2, 64'h8, 1'b1, 128'hD3, 64'h4044, 1'b0);
    op_d[4] = op1(64'h4040, 64'h4, 2'd2, 64'h8, 1'b1, 128'hD4, 64'h4058, 1'b0);
    op_w = op1(64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 2'd0, 64'h2, 1'b0, 128'hEE, 64'h1, 1'b0);
    op_f[0] = op1(64'h10, 64'h0, 2'd0, 64'h0, 1'b0, 128'hF0, 64'h10, 1'b0);
    op_f[1] = op1(64'h20, 64'h0, 2'd0, 64'h0, 1'b0, 128'hF1, 64'h20, 1'b0);
    op_f[2] = op1(64'h30, 64'h0, 2'd0, 64'h0, 1'b0, 128'hF2, 64'h30, 1'b0);
    op_h[0] = op1(64'h40, 64'h0, 2'd0, 64'h0, 1'b0, 128'h90, 64'h40, 1'b0);
    op_h[1] = op1(64'h50, 64'h0, 2'd0, 64'h0, 1'b0, 128'h91, 64'h50, 1'b0);
    op_g = op1(64'h500, 64'h2, 2'd2, 64'h1, 1'b1, 128'h66, 64'h509, 1'b0);
    op_k1 = op1(64'h0000_8000_0000_0000, 64'h0, 2'd0, 64'h0, 1'b0, 128'hCA, 64'h0000_8000_0000_0000, CANON);
    op_k2 = op1(64'hFFFF_8000_0000_0000, 64'h0, 2'd0, 64'h0, 1'b0, 128'hCB, 64'hFFFF_8000_0000_0000, 1'b0);
    op_k2.base = {64'h0, 64'h0001_0000_0000_0000, 64'hFFFF_8000_0000_0000};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("rst_addr", 256'(bus.addr_out), 256'(0));
    chk("rst_inflight", 256'(bus.inflight_out), 256'(0));
    chk("rst_fault", 256'(bus.fault_out), 256'(0));

    // Single op, two-cycle latency.
    bus.out_ready = 1'b1;
    drive(op_a);
    cyc();
    idle();
    @(negedge clk);
    chk("lat1_out_valid", 256'(bus.out_valid), 256'(0));
    chk("lat1_inflight", 256'(bus.inflight_out), 256'(1));
    cyc();
    @(negedge clk);
    chk("lat2_out_valid", 256'(bus.out_valid), 256'(1));
    cyc();
    @(negedge clk);
    chk("lat3_out_valid", 256'(bus.out_valid), 256'(0));
    chk("lat3_inflight", 256'(bus.inflight_out), 256'(0));

    send(op_b);
    drain(3);

    // Back-to-back at full throughput.
    for (int k = 0; k < 4; k++) begin
      drive(op_c[k]);
      @(negedge clk);
      chk("b2b_in_ready", 256'(bus.in_ready), 256'(1));
      chk("b2b_inflight", 256'(bus.inflight_out), 256'(b2b_inf[k]));
      cyc();
    end
    idle();
    drain(4);

    // Downstream stall with continuous upstream pressure.
    bus.out_ready = 1'b0;
    nxt = 0;
    for (int c = 0; c < 5; c++) begin
      drive(op_d[nxt]);
      @(negedge clk);
      chk("stall_in_ready", 256'(bus.in_ready), 256'(stall_rdy[c]));
      chk("stall_inflight", 256'(bus.inflight_out), 256'(stall_inf[c]));
      if (c == 2) begin
        held_addr = bus.addr_out;
        held_sb   = bus.sideband_out;
      end
      if (c > 2) begin
        chk("stall_addr_hold", 256'(bus.addr_out), 256'(held_addr));
        chk("stall_sb_hold", 256'(bus.sideband_out), 256'(held_sb));
      end
      if (stall_rdy[c] != 0) nxt++;
      cyc();
    end
    bus.out_ready = 1'b1;
    while (nxt < 5) begin
      send(op_d[nxt]);
      nxt++;
    end
    drain(4);

    send(op_w);
    drain(3);

    // Flush with two in flight and an op presented in the flush cycle.
    bus.out_ready = 1'b0;
    send(op_f[0]);
    send(op_f[1]);
    drive(op_f[2]);
    bus.flush = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("flush_in_ready", 256'(bus.in_ready), 256'(0));
    cyc();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush_out_valid", 256'(bus.out_valid), 256'(0));
    chk("flush_inflight", 256'(bus.inflight_out), 256'(0));
    bus.out_ready = 1'b1;
    drain(3);

    // Flush while S1 alone is occupied: ready must still be forced low.
    bus.out_ready = 1'b0;
    send(op_h[0]);
    drive(op_h[1]);
    bus.flush = 1'b1;
    expq.delete();
    @(negedge clk);
    chk("flush2_in_ready", 256'(bus.in_ready), 256'(0));
    cyc();
    bus.flush = 1'b0;
    idle();
    @(negedge clk);
    chk("flush2_inflight", 256'(bus.inflight_out), 256'(0));
    bus.out_ready = 1'b1;
    drain(3);
    send(op_g);
    drain(3);

    // Canonical-form cases, then reset in the middle of a stall.
    send(op_k1);
    send(op_k2);
    drain(3);
    bus.out_ready = 1'b0;
    send(op_k1);
    send(op_k2);
    @(negedge clk);
    chk("prerst_inflight", 256'(bus.inflight_out), 256'(2));
    cyc();
    reset = 1'b1;
    expq.delete();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("mrst_in_ready", 256'(bus.in_ready), 256'(1));
    chk("mrst_addr", 256'(bus.addr_out), 256'(0));
    chk("mrst_mem_en", 256'(bus.mem_en_out), 256'(0));
    chk("mrst_sideband", 256'(bus.sideband_out), 256'(0));
    chk("mrst_inflight", 256'(bus.inflight_out), 256'(0));
    chk("mrst_fault", 256'(bus.fault_out), 256'(0));
    bus.out_ready = 1'b1;
    drain(4);

    chk("queue_empty", 256'(expq.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
